yuv422_to_444_upsampler: RTL and testbench
==========================================

Name: yuv422_to_444_upsampler

Overview:
- Sits directly downstream of the TPG/vsampler AXI4-Stream video output.
- Converts 16-bit YUV 4:2:2 pixels (1 pixel/clk) into 24-bit YUV 4:4:4 pixels by replicating each pair's chroma.
- Feeds later 4:4:4 stages and the frame-capture bench.
- Full throughput of 1 pixel/clk when the sink is always ready.

Parameters:
- C_W, 8, bits per video component.
- NEUTRAL_C, 8'h80, chroma value inserted when a line ends on an unpaired even pixel.

Ports:
- aclk  in  1  video clock, all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_tdata  in  2*C_W  [C_W-1:0]=Y; [2C_W-1:C_W]=Cb on even pixels, Cr on odd pixels.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat accepted when s_tvalid&&s_tready.
- s_tuser  in  1  start of frame; valid on the first pixel only.
- s_tlast  in  1  end of line.
- m_tdata  out  3*C_W  [C_W-1:0]=Y, [2C_W-1:C_W]=Cb, [3C_W-1:2C_W]=Cr.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream ready.
- m_tuser  out  1  start of frame.
- m_tlast  out  1  end of line.

Behaviour:
- Reset (asynchronous, aresetn=0): m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, s_tready=0, state=EVEN, all held registers cleared. First accept is possible in the first cycle after release.
- Output register: one registered stage. out_free = !m_tvalid || m_tready. m_* hold stable while m_tvalid&&!m_tready.
- Pixel phase: the first beat after reset, after tlast, and any beat carrying tuser is "even". The next beat is "odd".
- States:
  - EVEN: s_tready=out_free. On accepting an even beat, store Y0, Cb, tuser. If s_tlast, go to LONE; otherwise go to ODD.
  - ODD: s_tready=out_free.
    - Accept with s_tuser=1 (phase error): drop the held even pixel, treat the beat as a new even pixel, and follow the EVEN rules (ODD or LONE).
    - Otherwise: load output {Cr,Cb,Y0} with tuser=stored tuser and tlast=0. Store Y1 and s_tlast, then go to EMIT2.
  - EMIT2: s_tready=out_free. When out_free, load {Cr,Cb,Y1} with tuser=0 and tlast=stored tlast. A concurrent accepted beat is an even pixel and is handled as in EVEN (go to ODD or LONE). With no concurrent beat, go to EVEN.
  - LONE: s_tready=0. When out_free, load {NEUTRAL_C,Cb,Y0} with tuser=stored tuser and tlast=1, then go to EVEN.
- Latency: the even pixel appears on m_* 1 cycle after its odd partner is accepted. The odd pixel appears 1 cycle later.
- Sustained rate is 1 pixel/clk with m_tready=1. Backpressure stalls s_tready the same cycle.
- Odd tlast on a Y1 beat ends the line normally. A beat is never dropped except the phase-error case.
- s_tready never depends on s_tdata.
- Reset mid-line discards all held pixels. No partial beat is emitted after reset.

Optional Feature:
- Macro: VSU_ERR_CNT_EN.
- When defined:
  - Adds output port err_cnt (16 bits): a saturating count of phase errors (tuser on an odd beat) plus odd-width lines (LONE entries).
  - Adds input port err_clr (1 bit): synchronous clear, taking priority over increment.
  - Two errors in the same cycle count as 1.
- When undefined: neither port nor the counter exists. Datapath behaviour is identical.

Decomposition:
- Package vsu_pkg holds:
  - state enum {EVEN, ODD, EMIT2, LONE};
  - localparam NEUTRAL_C default;
  - helper function packing {Cr,Cb,Y}.
- One sub-module, vsu_out_reg: the AXI4-Stream output register with a load/out_free interface, reused by later stages.

Test Plan:
- 480x640 YUV422 frame, m_tready=1 → 480 beats per line, 640 tlast per frame, one m_tuser on pixel 0. Pair (Y=10,Cb=20),(Y=11,Cr=30) produces outputs 0x1E140A then 0x1E140B.
- Same frame, m_tready toggling at random 50% → identical output sequence. m_* stable while stalled. No s_tready=1 while out_free=0.
- 3-pixel line (tlast on pixel 2, Y=5,Cb=7) → third output 0x800705 with m_tlast=1. err_cnt increments by 1 when VSU_ERR_CNT_EN is defined.
- tuser asserted on the 2nd beat of a frame → first pixel dropped, output frame starts with m_tuser on that beat. err_cnt increments by 1.
- aresetn pulsed low mid-line with an even pixel held → m_tvalid=0 immediately. After release, the next frame outputs start clean with no stale pixel.
- err_clr asserted while err_cnt=0xFFFF and an error event occurs in the same cycle → err_cnt=0.

Source files
------------

// File: rtl/vsu_pkg.sv
// Shared types and helpers for the YUV 4:2:2 -> 4:4:4 upsampler and the
// 4:4:4 stages after it.
package vsu_pkg;

    typedef enum logic [1:0] {
        EVEN  = 2'd0,
        ODD   = 2'd1,
        EMIT2 = 2'd2,
        LONE  = 2'd3
    } vsu_state_t;

    localparam int                 VSU_C_W       = 8;
    localparam logic [VSU_C_W-1:0] NEUTRAL_C_DEF = 8'h80;

    function automatic logic [3*VSU_C_W-1:0] pack444(
        input logic [VSU_C_W-1:0] y,
        input logic [VSU_C_W-1:0] cb,
        input logic [VSU_C_W-1:0] cr
    );
        return {cr, cb, y};
    endfunction

endpackage

// File: rtl/vsu_axis_if.sv
// AXI4-Stream video bundle (tdata/tvalid/tready/tuser/tlast) with
// master and slave views.
interface vsu_axis_if #(
    parameter int TW = 16
) ();
    logic [TW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tuser;
    logic          tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/vsu_out_reg.sv
// Single AXI4-Stream output register stage. The caller may assert load only
// while out_free is high; m holds steady while stalled.
module vsu_out_reg #(
    parameter int W = 24
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          load,
    input  logic [W-1:0]  ld_data,
    input  logic          ld_user,
    input  logic          ld_last,
    output logic          out_free,
    vsu_axis_if.master    m
);

    always_comb out_free = !m.tvalid || m.tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m.tvalid <= 1'b0;
            m.tdata  <= '0;
            m.tuser  <= 1'b0;
            m.tlast  <= 1'b0;
        end else if (load) begin
            m.tvalid <= 1'b1;
            m.tdata  <= ld_data;
            m.tuser  <= ld_user;
            m.tlast  <= ld_last;
        end else if (m.tready) begin
            m.tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/yuv422_to_444_upsampler.sv
// YUV 4:2:2 -> 4:4:4 upsampler: each even/odd pair shares its Cb/Cr.
// Optional error counter (err_cnt/err_clr) is built when VSU_ERR_CNT_EN is defined.
//
// state | meaning
// EVEN  | waiting for the first (Cb) pixel of a pair
// ODD   | even pixel held, waiting for its Cr partner
// EMIT2 | even pixel sent, odd pixel pending; may accept the next even beat
// LONE  | line ended on an unpaired even pixel; emit it with neutral Cr
module yuv422_to_444_upsampler
    import vsu_pkg::*;
#(
    parameter int           C_W       = VSU_C_W,
    parameter logic [C_W-1:0] NEUTRAL_C = NEUTRAL_C_DEF
) (
    input  logic        aclk,
    input  logic        aresetn,
`ifdef VSU_ERR_CNT_EN
    input  logic        err_clr,
    output logic [15:0] err_cnt,
`endif
    vsu_axis_if.slave   s,
    vsu_axis_if.master  m
);

    vsu_state_t       state, state_n;
    logic [C_W-1:0]   y0_q, cb_q, y1_q, cr_q;
    logic             user_q, last_q;
    logic             ready_en_q;
    logic             out_free, acc;
    logic             load, ld_user, ld_last;
    logic [3*C_W-1:0] ld_data;
    logic             cap_even, cap_odd;
    logic [C_W-1:0]   in_y, in_c;

    assign in_y = s.tdata[C_W-1:0];
    assign in_c = s.tdata[2*C_W-1:C_W];

    // ready_en_q keeps s.tready low while reset is asserted
    assign s.tready = ready_en_q && out_free && (state != LONE);
    assign acc      = s.tvalid && s.tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= EVEN;
            ready_en_q <= 1'b0;
            y0_q       <= '0;
            cb_q       <= '0;
            y1_q       <= '0;
            cr_q       <= '0;
            user_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state      <= state_n;
            ready_en_q <= 1'b1;
            if (cap_even) begin
                y0_q   <= in_y;
                cb_q   <= in_c;
                user_q <= s.tuser;
            end
            if (cap_odd) begin
                y1_q   <= in_y;
                cr_q   <= in_c;
                last_q <= s.tlast;
            end
        end
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        ld_data  = '0;
        ld_user  = 1'b0;
        ld_last  = 1'b0;
        cap_even = 1'b0;
        cap_odd  = 1'b0;
        unique case (state)
            EVEN: begin
                if (acc) begin
                    cap_even = 1'b1;
                    state_n  = s.tlast ? LONE : ODD;
                end
            end
            ODD: begin
                if (acc && s.tuser) begin
                    cap_even = 1'b1;
                    state_n  = s.tlast ? LONE : ODD;
                end else if (acc) begin
                    load    = 1'b1;
                    ld_data = pack444(y0_q, cb_q, in_c);
                    ld_user = user_q;
                    cap_odd = 1'b1;
                    state_n = EMIT2;
                end
            end
            EMIT2: begin
                if (out_free) begin
                    load    = 1'b1;
                    ld_data = pack444(y1_q, cb_q, cr_q);
                    ld_last = last_q;
                    state_n = EVEN;
                    if (acc) begin
                        cap_even = 1'b1;
                        state_n  = s.tlast ? LONE : ODD;
                    end
                end
            end
            LONE: begin
                if (out_free) begin
                    load    = 1'b1;
                    ld_data = pack444(y0_q, cb_q, NEUTRAL_C);
                    ld_user = user_q;
                    ld_last = 1'b1;
                    state_n = EVEN;
                end
            end
            default: state_n = EVEN;
        endcase
    end

    vsu_out_reg #(.W(3*C_W)) u_out_reg (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (load),
        .ld_data  (ld_data),
        .ld_user  (ld_user),
        .ld_last  (ld_last),
        .out_free (out_free),
        .m        (m)
    );

`ifdef VSU_ERR_CNT_EN
    logic err_phase, err_lone, err_evt;

    // a phase error that also ends the line counts once
    assign err_phase = (state == ODD) && acc && s.tuser;
    assign err_lone  = (state_n == LONE) && (state != LONE);
    assign err_evt   = err_phase || err_lone;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= '0;
        else if (err_evt && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_yuv422_to_444_upsampler.sv
// Directed bench for yuv422_to_444_upsampler; build with VSU_ERR_CNT_EN to
// also exercise err_cnt/err_clr.
module tb_yuv422_to_444_upsampler;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    vsu_axis_if #(.TW(16)) s_if ();
    vsu_axis_if #(.TW(24)) m_if ();

`ifdef VSU_ERR_CNT_EN
    logic        err_clr = 1'b0;
    logic [15:0] err_cnt;
`endif

    yuv422_to_444_upsampler dut (
        .aclk    (aclk),
        .aresetn (aresetn),
`ifdef VSU_ERR_CNT_EN
        .err_clr (err_clr),
        .err_cnt (err_cnt),
`endif
        .s       (s_if),
        .m       (m_if)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic        rand_rdy    = 1'b0;
    logic        hold_rdy    = 1'b1;
    logic        rdy         = 1'b1;
    logic [25:0] got_q[$];
    logic [25:0] exp_q[$];
    logic        prev_stall  = 1'b0;
    logic [26:0] prev_m      = '0;

    assign m_if.tready = rdy;

    always @(posedge aclk) begin
        #1;
        rdy = rand_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;
    end

    // capture accepted output beats, check stall stability and ready gating
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (m_if.tvalid && m_if.tready)
                got_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
            if (prev_stall) begin
                vectors++;
                if ({m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata} !== prev_m) begin
                    $display("FAIL stall_hold: got %h expected %h", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, prev_m);
                    miscompares++;
                end
            end
            if (m_if.tvalid && !m_if.tready) begin
                vectors++;
                if (s_if.tready !== 1'b0) begin
                    $display("FAIL ready_while_full: s_tready=%b expected 0", s_if.tready);
                    miscompares++;
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_m     = {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata};
        end
    end

    task automatic send(input logic [15:0] d, input logic u, input logic l);
        int n = 0;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_if.tready === 1'b1) break;
            n++;
            if (n > 1000) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: beat %h not accepted in %0d cycles", d, n);
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int c = 0;
        while (got_q.size() < n && c < 2000) begin
            @(negedge aclk);
            c++;
        end
        repeat (4) @(negedge aclk);
        vectors++;
        if (got_q.size() != n) begin
            $display("FAIL out_count: got %0d beats expected %0d", got_q.size(), n);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        aresetn     = 1'b0;
        repeat (3) @(negedge aclk);
        vectors += 5;
        if (m_if.tvalid !== 1'b0) begin $display("FAIL rst_tvalid: got %b expected 0", m_if.tvalid); miscompares++; end
        if (m_if.tdata !== 24'h0) begin $display("FAIL rst_tdata: got %h expected 0", m_if.tdata); miscompares++; end
        if (m_if.tuser !== 1'b0) begin $display("FAIL rst_tuser: got %b expected 0", m_if.tuser); miscompares++; end
        if (m_if.tlast !== 1'b0) begin $display("FAIL rst_tlast: got %b expected 0", m_if.tlast); miscompares++; end
        if (s_if.tready !== 1'b0) begin $display("FAIL rst_s_tready: got %b expected 0", s_if.tready); miscompares++; end
        #2 aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_pair();
        got_q.delete();
        exp_q = '{{2'b10, 24'h1E140A}, {2'b01, 24'h1E140B}};
        send(16'h140A, 1'b1, 1'b0);
        send(16'h1E0B, 1'b0, 1'b1);
        wait_out(2);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL pair[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_frame(input logic rnd);
        logic [7:0] y0, y1, cb, cr;
        int users = 0, lasts = 0;
        got_q.delete();
        exp_q.delete();
        rand_rdy = rnd;
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 8; p += 2) begin
                y0 = 8'(l * 16 + p);
                y1 = 8'(l * 16 + p + 1);
                cb = 8'(8'h20 + l * 16 + p);
                cr = 8'(8'h40 + l * 16 + p + 1);
                exp_q.push_back({(l == 0 && p == 0), 1'b0, cr, cb, y0});
                exp_q.push_back({1'b0, (p == 6), cr, cb, y1});
                send({cb, y0}, (l == 0 && p == 0), 1'b0);
                send({cr, y1}, 1'b0, (p == 6));
            end
        end
        wait_out(32);
        rand_rdy = 1'b0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL frame%0d[%0d]: got %h expected %h", rnd, i, got_q[i], exp_q[i]);
                miscompares++;
            end
            users += int'(got_q[i][25]);
            lasts += int'(got_q[i][24]);
        end
        vectors += 2;
        if (users != 1) begin $display("FAIL frame%0d_tuser_count: got %0d expected 1", rnd, users); miscompares++; end
        if (lasts != 4) begin $display("FAIL frame%0d_tlast_count: got %0d expected 4", rnd, lasts); miscompares++; end
    endtask

    task automatic test_odd_line();
        got_q.delete();
        exp_q = '{{2'b10, 24'h040201}, {2'b00, 24'h040203}, {2'b01, 24'h800705}};
        send(16'h0201, 1'b1, 1'b0);
        send(16'h0403, 1'b0, 1'b0);
        send(16'h0705, 1'b0, 1'b1);
        wait_out(3);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL odd_line[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                miscompares++;
            end
        end
`ifdef VSU_ERR_CNT_EN
        vectors++;
        if (err_cnt !== 16'd1) begin $display("FAIL odd_line_err_cnt: got %0d expected 1", err_cnt); miscompares++; end
`endif
    endtask

    task automatic test_phase_err();
        got_q.delete();
        exp_q = '{{2'b10, 24'h664433}, {2'b01, 24'h664455}};
        send(16'h2211, 1'b1, 1'b0);
        send(16'h4433, 1'b1, 1'b0);
        send(16'h6655, 1'b0, 1'b1);
        wait_out(2);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL phase_err[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                miscompares++;
            end
        end
`ifdef VSU_ERR_CNT_EN
        vectors++;
        if (err_cnt !== 16'd2) begin $display("FAIL phase_err_cnt: got %0d expected 2", err_cnt); miscompares++; end
`endif
    endtask

`ifdef VSU_ERR_CNT_EN
    task automatic test_err_clr();
        got_q.delete();
        err_clr = 1'b1;
        send(16'h0101, 1'b1, 1'b0);
        send(16'h0202, 1'b1, 1'b0);
        err_clr = 1'b0;
        send(16'h0303, 1'b0, 1'b1);
        wait_out(2);
        vectors++;
        if (err_cnt !== 16'd0) begin $display("FAIL err_clr_priority: got %0d expected 0", err_cnt); miscompares++; end
    endtask
`endif

    task automatic test_reset_midline();
        hold_rdy = 1'b0;
        @(posedge aclk);
        #2;
        got_q.delete();
        send(16'h0201, 1'b1, 1'b0);
        send(16'h0403, 1'b0, 1'b0);
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        vectors += 3;
        if (m_if.tvalid !== 1'b0) begin $display("FAIL mid_rst_tvalid: got %b expected 0", m_if.tvalid); miscompares++; end
        if (m_if.tdata !== 24'h0) begin $display("FAIL mid_rst_tdata: got %h expected 0", m_if.tdata); miscompares++; end
        if (s_if.tready !== 1'b0) begin $display("FAIL mid_rst_s_tready: got %b expected 0", s_if.tready); miscompares++; end
        @(negedge aclk);
        #2 aresetn = 1'b1;
        hold_rdy = 1'b1;
        repeat (5) @(negedge aclk);
        vectors++;
        if (got_q.size() != 0) begin $display("FAIL stale_after_rst: got %0d beats expected 0", got_q.size()); miscompares++; end
        @(posedge aclk);
        #1;
        exp_q = '{{2'b10, 24'h080605}, {2'b01, 24'h080607}};
        send(16'h0605, 1'b1, 1'b0);
        send(16'h0807, 1'b0, 1'b1);
        wait_out(2);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL post_rst[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_frame(1'b0);
        test_frame(1'b1);
        test_odd_line();
        test_phase_err();
`ifdef VSU_ERR_CNT_EN
        test_err_clr();
`endif
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
